// File: rtl/lp_event_core.sv
// Core-side endpoint of the queue<->core event protocol: accepts one event, waits out
// monitor stalls, processes for a fixed time and returns one follow-on event.
module lp_event_core #(
  parameter int MSG_WID     = 32,
  parameter int TIME_WID    = 16,
  parameter int NUM_LP      = 8,
  parameter int CORE_ID     = 0,
  parameter int PROC_CYCLES = 4,
  parameter int DELAY       = 10,
  parameter int LP_STRIDE   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_vld,
  input  logic [MSG_WID-1:0] in_msg,
  output logic               in_rdy,
  input  logic               stall,
  input  logic [3:0]         hist_cnt,
  output logic               out_vld,
  output logic [MSG_WID-1:0] out_msg,
  input  logic               out_rdy,
  output logic               busy,
  output logic [15:0]        evt_cnt
);

  localparam int NB_LP = $clog2(NUM_LP);
  localparam int CNT_W = $clog2(PROC_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PROC = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t              state_r;
  logic [TIME_WID-1:0] time_r;
  logic [NB_LP-1:0]    lp_r;
  logic [3:0]          hist_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [TIME_WID:0]   time_sum_s;
  logic [TIME_WID-1:0] time_nxt_s;
  logic [NB_LP-1:0]    lp_nxt_s;
  logic [3:0]          hist_nxt_s;
  logic [MSG_WID-1:0]  msg_nxt_s;
  logic                unused_s;

  // Upper input message bits and the core index play no part in the datapath.
  assign unused_s = ^{in_msg[MSG_WID-1:TIME_WID+NB_LP], 1'(CORE_ID)};

  // Follow-on event fields: clamped timestamp, wrapped LP id, saturated history.
  always_comb begin
    time_sum_s = {1'b0, time_r} + (TIME_WID+1)'(DELAY);
    if (time_sum_s[TIME_WID]) begin
      time_nxt_s = '1;
    end else begin
      time_nxt_s = time_sum_s[TIME_WID-1:0];
    end
    lp_nxt_s = lp_r + NB_LP'(LP_STRIDE);
    if (hist_r == 4'hF) begin
      hist_nxt_s = 4'hF;
    end else begin
      hist_nxt_s = hist_r + 4'd1;
    end
    msg_nxt_s                      = '0;
    msg_nxt_s[TIME_WID-1:0]        = time_nxt_s;
    msg_nxt_s[TIME_WID +: NB_LP]   = lp_nxt_s;
    msg_nxt_s[MSG_WID-1 -: 4]      = hist_nxt_s;
  end

  // Event FSM with registered handshake outputs and return counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
      out_msg <= '0;
      busy    <= 1'b0;
      evt_cnt <= 16'd0;
      time_r  <= '0;
      lp_r    <= '0;
      hist_r  <= 4'd0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_vld && in_rdy) begin
            time_r  <= in_msg[TIME_WID-1:0];
            lp_r    <= in_msg[TIME_WID +: NB_LP];
            in_rdy  <= 1'b0;
            busy    <= 1'b1;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          // History is taken at the cycle the monitor releases the stall.
          if (!stall) begin
            hist_r  <= hist_cnt;
            cnt_r   <= CNT_W'(PROC_CYCLES - 1);
            state_r <= PROC;
          end
        end
        PROC: begin
          if (cnt_r == '0) begin
            out_msg <= msg_nxt_s;
            out_vld <= 1'b1;
            state_r <= SEND;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        SEND: begin
          if (out_rdy) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            busy    <= 1'b0;
            evt_cnt <= evt_cnt + 16'd1;
            state_r <= IDLE;
          end
        end
        default: begin
          out_vld <= 1'b0;
          in_rdy  <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
